rbcp_wb_decoder: RTL

Wishbone address decoder and bus watchdog that sits directly downstream of the RBCP-to-Wishbone bridge. It accepts the bridge's single 8-bit Wishbone master port and routes each cycle to one of `NSLV` register-bank slaves by address window. It returns the slave's data and termination to the bridge. Unmapped addresses and silent slaves are terminated with `m_err`, so an RBCP access can never hang the bus.

---
 rtl/rbcp_wb_decoder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rbcp_wb_decoder.sv
// Wishbone address decoder and bus watchdog behind the RBCP-to-Wishbone bridge.
// Latency: slave strobes one cycle after the request; master termination one cycle after the slave's.
// Backpressure: a silent slave is cut off after TIMEOUT cycles with m_err; no new cycle until m_cyc drops.
module rbcp_wb_decoder #(
   parameter int                 NSLV     = 2,
   parameter logic [NSLV*32-1:0] SLV_BASE = {32'h0000_0100, 32'h0000_0000},
   parameter logic [NSLV*32-1:0] SLV_MASK = {32'hFFFF_FF00, 32'hFFFF_FF00},
   parameter int                 TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         m_adr,
   input  logic [7:0]          m_dat_i,
   output logic [7:0]          m_dat_o,
   input  logic                m_cyc,
   input  logic                m_stb,
   input  logic                m_we,
   input  logic                m_sel,
   output logic                m_ack,
   output logic                m_err,
   output logic                m_rty,
   output logic [31:0]         s_adr,
   output logic [7:0]          s_dat_o,
   input  logic [NSLV*8-1:0]   s_dat_i,
   output logic [NSLV-1:0]     s_cyc,
   output logic [NSLV-1:0]     s_stb,
   output logic                s_we,
   output logic                s_sel,
   input  logic [NSLV-1:0]     s_ack,
   input  logic [NSLV-1:0]     s_err,
   input  logic [NSLV-1:0]     s_rty,
   output logic [7:0]          err_cnt,
   output logic [31:0]         err_adr
);

   localparam int          SW      = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t           state, state_nx;
   logic [SW-1:0]    sel;
   logic [15:0]      wd_cnt;

   logic             hit;
   logic [SW-1:0]    hit_idx;
   logic [NSLV-1:0]  hit_oh;
   logic             start_hit, start_miss;
   logic             do_ack, do_err, do_rty, do_tmo, do_abort;

   // Select is always driven high for a decoded access; the master's value is not forwarded.
   logic unused_m_sel;
   assign unused_m_sel = m_sel;

   // Address decode (lowest index wins) and next-state / event selection.
   always_comb begin
      state_nx   = state;
      hit        = 1'b0;
      hit_idx    = '0;
      hit_oh     = '0;
      start_hit  = 1'b0;
      start_miss = 1'b0;
      do_ack     = 1'b0;
      do_err     = 1'b0;
      do_rty     = 1'b0;
      do_tmo     = 1'b0;
      do_abort   = 1'b0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((m_adr & SLV_MASK[i*32 +: 32]) == (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32])) begin
            hit        = 1'b1;
            hit_idx    = SW'(i);
            hit_oh     = '0;
            hit_oh[i]  = 1'b1;
         end
      end
      case (state)
         IDLE: begin
            if (m_cyc && m_stb) begin
               if (hit) begin
                  start_hit = 1'b1;
                  state_nx  = ACTIVE;
               end else begin
                  start_miss = 1'b1;
                  state_nx   = DONE;
               end
            end
         end
         ACTIVE: begin
            // A vanished master outranks any termination: nobody is left to receive it.
            if (!m_cyc) begin
               do_abort = 1'b1;
               state_nx = IDLE;
            end else if (s_ack[sel]) begin
               do_ack   = 1'b1;
               state_nx = DONE;
            end else if (s_err[sel]) begin
               do_err   = 1'b1;
               state_nx = DONE;
            end else if (s_rty[sel]) begin
               do_rty   = 1'b1;
               state_nx = DONE;
            end else if (wd_cnt == WD_LAST) begin
               do_tmo   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            if (!m_cyc) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Slave-side latches, strobes, watchdog and master terminations.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel     <= '0;
         wd_cnt  <= '0;
         s_adr   <= '0;
         s_dat_o <= '0;
         s_we    <= 1'b0;
         s_sel   <= 1'b0;
         s_cyc   <= '0;
         s_stb   <= '0;
         m_dat_o <= '0;
         m_ack   <= 1'b0;
         m_err   <= 1'b0;
         m_rty   <= 1'b0;
      end else begin
         m_ack <= do_ack;
         m_err <= do_err | do_tmo | start_miss;
         m_rty <= do_rty;
         if (start_hit || start_miss) begin
            s_adr   <= m_adr;
            s_dat_o <= m_dat_i;
            s_we    <= m_we;
         end
         if (start_hit) begin
            sel    <= hit_idx;
            s_cyc  <= hit_oh;
            s_stb  <= hit_oh;
            s_sel  <= 1'b1;
            wd_cnt <= '0;
         end else if (state == ACTIVE) begin
            wd_cnt <= wd_cnt + 16'd1;
         end
         if (do_ack) m_dat_o <= s_dat_i[{sel, 3'b000} +: 8];
         if (do_ack || do_err || do_rty || do_tmo || do_abort) begin
            s_cyc <= '0;
            s_stb <= '0;
            s_sel <= 1'b0;
         end
      end
   end

   // Log of errors the decoder itself generates (unmapped address, watchdog).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
         err_adr <= '0;
      end else if (start_miss || do_tmo) begin
         if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         err_adr <= start_miss ? m_adr : s_adr;
      end
   end

endmodule
